// File: rtl/mxu_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : mxu_accumulator
// Purpose  : Per-column result buffer for a matrix unit. A FILL pass captures
//            (or accumulates onto) the partial sums leaving the column's
//            bottom MAC. A DRAIN pass streams the buffer out over a
//            valid/ready handshake.
// Ports    : clk        - single clock, rising edge
//            sclr       - synchronous active-high reset (beats ce)
//            ce         - clock enable; all state holds while low
//            start      - begin a fill pass (IDLE only)
//            acc_en     - sampled with start: 0 overwrite, 1 accumulate
//            len        - sampled with start: pass length (0 or >DEPTH = DEPTH)
//            res_mac_n  - partial sum from the bottom MAC
//            res_valid  - qualifies res_mac_n during FILL
//            drain      - begin readout (IDLE only, start has priority)
//            out_data   - drained entry
//            out_valid  - qualifies out_data (DRAIN only)
//            out_ready  - consumer accept
//            busy       - state is not IDLE
//            done       - one-cycle pulse after a pass completes
// Config   : ACC_SATURATE_EN - when defined, accumulate passes clamp on
//            signed overflow; otherwise the sum wraps.
// Revision : 1.0 - initial release
// ============================================================================
module mxu_accumulator #(
    parameter int  bit_width = 64,
    parameter int  DEPTH     = 16,
    localparam int AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                 clk,
    input  logic                 sclr,
    input  logic                 ce,
    input  logic                 start,
    input  logic                 acc_en,
    input  logic [AW:0]          len,
    input  logic [bit_width-1:0] res_mac_n,
    input  logic                 res_valid,
    input  logic                 drain,
    output logic [bit_width-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 busy,
    output logic                 done
);

    localparam logic [1:0]    c_IDLE    = 2'd0;
    localparam logic [1:0]    c_FILL    = 2'd1;
    localparam logic [1:0]    c_DRAIN   = 2'd2;
    localparam logic [AW:0]   c_DEPTH   = (AW+1)'(DEPTH);
    localparam logic [AW:0]   c_LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

    logic [1:0]           state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          len_q, len_d;
    logic                 acc_q, acc_d;
    logic                 done_q, done_d;
    logic [bit_width-1:0] mem_q [DEPTH];
    logic [bit_width-1:0] mem_d [DEPTH];

    logic [AW:0]          w_eff_len;
    logic [AW:0]          w_len_m1;
    logic                 w_wr_last;
    logic                 w_rd_last;
    logic [bit_width-1:0] w_sum;
    logic [bit_width-1:0] w_acc_res;
    logic [bit_width-1:0] w_wr_data;

    // A zero or oversized request means "the whole buffer".
    assign w_eff_len = ((len == '0) || (len > c_DEPTH)) ? c_DEPTH : len;
    assign w_len_m1  = len_q - c_LEN_ONE;
    assign w_wr_last = ({1'b0, wr_ptr_q} == w_len_m1);
    assign w_rd_last = ({1'b0, rd_ptr_q} == w_len_m1);

    assign w_sum = mem_q[wr_ptr_q] + res_mac_n;

`ifdef ACC_SATURATE_EN
    // Signed overflow: both operands share a sign that the sum does not.
    logic w_pos_ovf;
    logic w_neg_ovf;
    assign w_pos_ovf = ~mem_q[wr_ptr_q][bit_width-1] & ~res_mac_n[bit_width-1] &  w_sum[bit_width-1];
    assign w_neg_ovf =  mem_q[wr_ptr_q][bit_width-1] &  res_mac_n[bit_width-1] & ~w_sum[bit_width-1];

    always_comb begin : p_saturate
        w_acc_res = w_sum;
        if (w_pos_ovf) begin
            w_acc_res = {1'b0, {(bit_width-1){1'b1}}};
        end else if (w_neg_ovf) begin
            w_acc_res = {1'b1, {(bit_width-1){1'b0}}};
        end
    end
`else
    assign w_acc_res = w_sum;
`endif

    assign w_wr_data = acc_q ? w_acc_res : res_mac_n;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin : p_state_reg
        if (sclr) begin
            state_q <= c_IDLE;
        end else if (ce) begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin : p_next_state
        state_d = state_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_FILL;
                end else if (drain) begin
                    state_d = c_DRAIN;
                end
            end
            c_FILL: begin
                if (res_valid && w_wr_last) begin
                    state_d = c_IDLE;
                end
            end
            c_DRAIN: begin
                if (out_ready && w_rd_last) begin
                    state_d = c_IDLE;
                end
            end
            default: state_d = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values (pointers, pass config, buffer, done)
    // ------------------------------------------------------------------
    always_comb begin : p_datapath
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        acc_d    = acc_q;
        done_d   = 1'b0;
        mem_d    = mem_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    acc_d    = acc_en;
                    len_d    = w_eff_len;
                    wr_ptr_d = '0;
                end else if (drain) begin
                    rd_ptr_d = '0;
                end
            end
            c_FILL: begin
                if (res_valid) begin
                    mem_d[wr_ptr_q] = w_wr_data;
                    // The last pointer is not advanced so it never passes length-1.
                    if (w_wr_last) begin
                        done_d = 1'b1;
                    end else begin
                        wr_ptr_d = wr_ptr_q + c_PTR_ONE;
                    end
                end
            end
            c_DRAIN: begin
                if (out_ready) begin
                    if (w_rd_last) begin
                        done_d = 1'b1;
                    end else begin
                        rd_ptr_d = rd_ptr_q + c_PTR_ONE;
                    end
                end
            end
            default: ;
        endcase
    end

    // Before any pass the drain length is the whole buffer.
    always_ff @(posedge clk) begin : p_data_reg
        if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= c_DEPTH;
            acc_q    <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (ce) begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            acc_q    <= acc_d;
            done_q   <= done_d;
            mem_q    <= mem_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin : p_outputs
        busy      = (state_q != c_IDLE);
        out_valid = (state_q == c_DRAIN);
        out_data  = mem_q[rd_ptr_q];
        done      = done_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_mxu_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_mxu_accumulator
// Purpose  : Self-checking bench for mxu_accumulator (bit_width=64, DEPTH=16).
//            Directed scenarios followed by randomized fill/drain passes,
//            compared against a buffer model kept as a plain array.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mxu_accumulator;

    logic        clk = 1'b0;
    logic        sclr, ce, start, acc_en, res_valid, drain, out_ready;
    logic [4:0]  len;
    logic [63:0] res_mac_n;
    logic [63:0] out_data;
    logic        out_valid, busy, done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] model_mem [16];
    int          model_len;
    logic [63:0] drained   [16];
    logic [63:0] dir_data  [16];
    int          use_dir;

    mxu_accumulator #(.bit_width(64), .DEPTH(16)) dut (
        .clk       (clk),
        .sclr      (sclr),
        .ce        (ce),
        .start     (start),
        .acc_en    (acc_en),
        .len       (len),
        .res_mac_n (res_mac_n),
        .res_valid (res_valid),
        .drain     (drain),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Signed add evaluated exactly in a wider range, then clamped or wrapped.
    function automatic logic [63:0] acc_add(input logic [63:0] a, input logic [63:0] b);
        logic signed [65:0] s;
        logic signed [65:0] maxv;
        logic signed [65:0] minv;
        s    = $signed({{2{a[63]}}, a}) + $signed({{2{b[63]}}, b});
        maxv = $signed({2'b00, 1'b0, {63{1'b1}}});
        minv = $signed({2'b11, 1'b1, {63{1'b0}}});
`ifdef ACC_SATURATE_EN
        if (s > maxv) s = maxv;
        if (s < minv) s = minv;
`else
        if (s > maxv) s = s - (66'sd1 <<< 64);
        if (s < minv) s = s + (66'sd1 <<< 64);
`endif
        return s[63:0];
    endfunction

    function automatic logic [63:0] pick_data();
        logic [63:0] base;
        case ($urandom % 4)
            0: begin base = 64'h7FFF_FFFF_FFFF_FFF0; return base + 64'($urandom % 32); end
            1: begin base = 64'h8000_0000_0000_0000; return base + 64'($urandom % 32); end
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        model_len = 16;
    endtask

    // One fill pass; drain is raised together with start (start must win).
    task automatic fill_pass(input logic [4:0] l, input logic acc, input int gaps);
        int eff;
        int n;
        eff = (l == 0 || l > 16) ? 16 : int'(l);
        ce = 1'b1; start = 1'b1; drain = 1'b1; acc_en = acc; len = l;
        res_valid = $urandom % 2; res_mac_n = pick_data();
        tick();
        start = 1'b0; drain = 1'b0; res_valid = 1'b0;
        check("fill_busy", {63'd0, busy}, 64'd1);
        check("fill_no_valid", {63'd0, out_valid}, 64'd0);
        model_len = eff;
        n = 0;
        while (n < eff) begin
            start = $urandom % 2; drain = $urandom % 2; len = 5'($urandom); acc_en = ~acc;
            if (gaps != 0 && ($urandom % 3) == 0) begin
                ce = 1'b1; res_valid = 1'b0;
            end else if (gaps != 0 && ($urandom % 4) == 0) begin
                ce = 1'b0; res_valid = 1'b1;
            end else begin
                ce = 1'b1; res_valid = 1'b1;
            end
            res_mac_n = (use_dir != 0) ? dir_data[n] : pick_data();
            if (ce && res_valid) begin
                model_mem[n] = acc ? acc_add(model_mem[n], res_mac_n) : res_mac_n;
                n++;
            end
            tick();
            start = 1'b0; drain = 1'b0; res_valid = 1'b0; ce = 1'b1;
            if (n < eff) begin
                check("fill_mid_busy", {63'd0, busy}, 64'd1);
                check("fill_mid_done", {63'd0, done}, 64'd0);
            end
        end
        check("fill_end_busy", {63'd0, busy}, 64'd0);
        check("fill_end_done", {63'd0, done}, 64'd1);
        check("fill_end_valid", {63'd0, out_valid}, 64'd0);
    endtask

    // mode 0: always ready; 1: random ready and ce; 2: ready pattern 1,0,0,1,1,1
    task automatic drain_pass(input int mode);
        int idx;
        int cyc;
        logic [5:0] pat;
        pat = 6'b111001;
        ce = 1'b1; drain = 1'b1; start = 1'b0;
        tick();
        drain = 1'b0;
        check("drain_busy", {63'd0, busy}, 64'd1);
        idx = 0;
        cyc = 0;
        while (idx < model_len && cyc < 300) begin
            check("drain_valid", {63'd0, out_valid}, 64'd1);
            check("drain_data", out_data, model_mem[idx]);
            drained[idx] = out_data;
            case (mode)
                0: begin out_ready = 1'b1; ce = 1'b1; end
                2: begin out_ready = (cyc < 6) ? pat[cyc] : 1'b1; ce = 1'b1; end
                default: begin out_ready = $urandom % 2; ce = ($urandom % 4) != 0; end
            endcase
            res_valid = $urandom % 2; res_mac_n = pick_data(); start = $urandom % 2;
            if (ce && out_ready) idx++;
            tick();
            cyc++;
            out_ready = 1'b0; res_valid = 1'b0; start = 1'b0; ce = 1'b1;
        end
        check("drain_in_budget", {63'd0, (cyc < 300)}, 64'd1);
        check("drain_end_busy", {63'd0, busy}, 64'd0);
        check("drain_end_done", {63'd0, done}, 64'd1);
        check("drain_end_valid", {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        sclr = 1'b1; ce = 1'b1; start = 1'b0; acc_en = 1'b0; len = '0;
        res_mac_n = '0; res_valid = 1'b0; drain = 1'b0; out_ready = 1'b0;
        use_dir = 0;
        model_reset();
        tick();
        tick();
        sclr = 1'b0;
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_valid", {63'd0, out_valid}, 64'd0);

        // Overwrite 1..4 then drain back-to-back.
        use_dir = 1;
        for (int i = 0; i < 16; i++) dir_data[i] = 64'(i + 1);
        fill_pass(5'd4, 1'b0, 0);
        drain_pass(0);
        for (int i = 0; i < 4; i++) check("ovw_value", drained[i], 64'(i + 1));
        tick();
        check("done_single_pulse", {63'd0, done}, 64'd0);

        // Accumulate 10,20,30,40 onto 1..4.
        for (int i = 0; i < 16; i++) dir_data[i] = 64'(10 * (i + 1));
        fill_pass(5'd4, 1'b1, 0);
        // done must hold while ce is low.
        ce = 1'b0;
        tick();
        check("ce_hold_done", {63'd0, done}, 64'd1);
        ce = 1'b1;
        tick();
        check("done_clears", {63'd0, done}, 64'd0);
        drain_pass(0);
        for (int i = 0; i < 4; i++) check("acc_value", drained[i], 64'(11 * (i + 1)));

        // Positive overflow on accumulate.
        dir_data[0] = 64'h7FFF_FFFF_FFFF_FFFF;
        fill_pass(5'd1, 1'b0, 0);
        dir_data[0] = 64'd1;
        fill_pass(5'd1, 1'b1, 0);
        drain_pass(0);
`ifdef ACC_SATURATE_EN
        check("ovf_sat", drained[0], 64'h7FFF_FFFF_FFFF_FFFF);
`else
        check("ovf_wrap", drained[0], 64'h8000_0000_0000_0000);
`endif

        // Backpressure pattern.
        for (int i = 0; i < 16; i++) dir_data[i] = 64'hA0 + 64'(i);
        fill_pass(5'd4, 1'b0, 0);
        drain_pass(2);
        for (int i = 0; i < 4; i++) check("bp_value", drained[i], 64'hA0 + 64'(i));

        // Reset after 2 of 4 writes, with ce low to confirm reset priority.
        start = 1'b1; len = 5'd4; acc_en = 1'b0;
        tick();
        start = 1'b0; res_valid = 1'b1; res_mac_n = 64'd5;
        tick();
        res_mac_n = 64'd6;
        tick();
        res_valid = 1'b0; ce = 1'b0; sclr = 1'b1;
        tick();
        sclr = 1'b0; ce = 1'b1;
        model_reset();
        check("midfill_rst_busy", {63'd0, busy}, 64'd0);
        check("midfill_rst_done", {63'd0, done}, 64'd0);
        drain_pass(0);
        for (int i = 0; i < 16; i++) check("rst_zero", drained[i], 64'd0);

        // len=0 means 16 entries; start noise during FILL is ignored.
        use_dir = 0;
        fill_pass(5'd0, 1'b0, 1);
        drain_pass(0);

        // Randomized passes.
        for (int k = 0; k < 10; k++) begin
            fill_pass(5'($urandom_range(0, 31)), 1'($urandom % 2), 1);
            drain_pass(1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
